mem_bus_arbiter: RTL and testbench

- Registered arbiter that shares the single RAM port between CPUS data-cache requesters and CPUS instruction-cache requesters.
- Data transactions are multi-word bursts; instruction fetches are single words.
- Issues one-hot grants and a beat index, sequences bursts on RAM-access acknowledgements, and applies round-robin fairness with a starvation guard for fetches.
- Sits between the caches and the memory controller's RAM-side datapath.

---
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM port between data-cache bursts and
// instruction-cache single-word fetches, with a starvation guard for fetches.
//
// Ports:
//   CLK      in   rising-edge clock
//   nRST     in   asynchronous active-low reset
//   dreq     in   [CPUS]  per-core data request, held until the burst ends
//   ireq     in   [CPUS]  per-core instruction fetch request
//   ram_ack  in   RAM finished an access this cycle
//   dgrant   out  [CPUS]  one-hot data grant
//   igrant   out  [CPUS]  one-hot fetch grant
//   word_idx out  [WW]    current beat within the data burst
//   busy     out  a grant is held
module mem_bus_arbiter #(
    parameter int CPUS         = 2,
    parameter int BURST        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int WW = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] dreq,
    input  logic [CPUS-1:0] ireq,
    input  logic            ram_ack,
    output logic [CPUS-1:0] dgrant,
    output logic [CPUS-1:0] igrant,
    output logic [WW-1:0]   word_idx,
    output logic            busy
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] INSTR = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] dptr;
    logic [PW-1:0] iptr;
    logic [PW-1:0] cur;
    logic [SW-1:0] starve_cnt;

    logic [PW-1:0] dwin;
    logic [PW-1:0] iwin;
    logic          d_any;
    logic          i_any;
    logic          i_fin;
    logic          starved;

    // First asserted requester at or above ptr, wrapping modulo CPUS.
    function automatic logic [PW-1:0] rr_pick(
        input logic [CPUS-1:0] req,
        input logic [PW-1:0]   ptr
    );
        logic [PW-1:0] res;
        logic          found;
        int            idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CPUS) idx = idx - CPUS;
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = PW'(idx);
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(CPUS - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CPUS-1:0] onehot(input logic [PW-1:0] p);
        logic [CPUS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    always_comb begin
        dwin    = rr_pick(dreq, dptr);
        iwin    = rr_pick(ireq, iptr);
        d_any   = |dreq;
        i_any   = |ireq;
        starved = i_any && (starve_cnt == SW'(STARVE_LIMIT));
        // A fetch completes only if its request is still held when acked.
        i_fin   = (state == INSTR) && ireq[cur] && ram_ack;
    end

    assign busy = (|dgrant) | (|igrant);

    // Starvation counter: the clear (no fetch pending, or fetch done) wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!i_any || i_fin) begin
            starve_cnt <= '0;
        end else if ((igrant == '0) && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            dgrant   <= '0;
            igrant   <= '0;
            word_idx <= '0;
            dptr     <= '0;
            iptr     <= '0;
            cur      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Grants are only issued from IDLE, which guarantees one
                    // idle turnaround cycle between consecutive grants.
                    if (starved) begin
                        state  <= INSTR;
                        igrant <= onehot(iwin);
                        cur    <= iwin;
                    end else if (d_any) begin
                        state    <= DATA;
                        dgrant   <= onehot(dwin);
                        cur      <= dwin;
                        word_idx <= '0;
                    end else if (i_any) begin
                        state  <= INSTR;
                        igrant <= onehot(iwin);
                        cur    <= iwin;
                    end
                end
                DATA: begin
                    if (!dreq[cur]) begin
                        // Abort: any ack this cycle is discarded.
                        state    <= IDLE;
                        dgrant   <= '0;
                        word_idx <= '0;
                        dptr     <= ptr_next(cur);
                    end else if (ram_ack) begin
                        if (word_idx == WW'(BURST - 1)) begin
                            state    <= IDLE;
                            dgrant   <= '0;
                            word_idx <= '0;
                            dptr     <= ptr_next(cur);
                        end else begin
                            word_idx <= word_idx + WW'(1);
                        end
                    end
                end
                INSTR: begin
                    if (!ireq[cur] || ram_ack) begin
                        state  <= IDLE;
                        igrant <= '0;
                        iptr   <= ptr_next(cur);
                    end
                end
                default: begin
                    state    <= IDLE;
                    dgrant   <= '0;
                    igrant   <= '0;
                    word_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with default parameters
// (CPUS=2, BURST=2, STARVE_LIMIT=4).
module tb_mem_bus_arbiter;

    logic       CLK;
    logic       nRST;
    logic [1:0] dreq;
    logic [1:0] ireq;
    logic       ram_ack;
    logic [1:0] dgrant;
    logic [1:0] igrant;
    logic [0:0] word_idx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dreq     (dreq),
        .ireq     (ireq),
        .ram_ack  (ram_ack),
        .dgrant   (dgrant),
        .igrant   (igrant),
        .word_idx (word_idx),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {busy, dgrant, igrant, word_idx} for a single comparison.
    task automatic chk_out(input string tag, input logic [1:0] dg,
                           input logic [1:0] ig, input logic wi,
                           input logic b);
        chk(tag, 32'({busy, dgrant, igrant, word_idx}),
            32'({b, dg, ig, wi}));
    endtask

    // Grant invariants, checked on every falling edge out of reset.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            total++;
            assert ($onehot0({dgrant, igrant}) &&
                    (busy === (|{dgrant, igrant}))) else begin
                bad++;
                $error("FAIL invariant observed=%b_%b_%b expected=onehot0",
                       busy, dgrant, igrant);
            end
        end
    end

    initial begin
        nRST    = 1'b0;
        dreq    = 2'b00;
        ireq    = 2'b00;
        ram_ack = 1'b0;
        tick();
        tick();
        chk_out("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        nRST = 1'b1;
        tick();
        chk_out("idle_after_reset", 2'b00, 2'b00, 1'b0, 1'b0);

        // Single burst: grant one cycle after request.
        dreq = 2'b01;
        tick();
        chk_out("burst_grant", 2'b01, 2'b00, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("burst_beat1", 2'b01, 2'b00, 1'b1, 1'b1);
        ram_ack = 1'b0;
        tick();
        chk_out("burst_hold", 2'b01, 2'b00, 1'b1, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("burst_done", 2'b00, 2'b00, 1'b0, 1'b0);
        dreq    = 2'b00;
        ram_ack = 1'b0;
        tick();
        chk_out("burst_idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Data round-robin: dptr is now 1.
        dreq    = 2'b11;
        ram_ack = 1'b1;
        tick();
        chk_out("rr_g1", 2'b10, 2'b00, 1'b0, 1'b1);
        tick();
        chk_out("rr_g1_b1", 2'b10, 2'b00, 1'b1, 1'b1);
        tick();
        chk_out("rr_gap1", 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("rr_g2", 2'b01, 2'b00, 1'b0, 1'b1);
        tick();
        chk_out("rr_g2_b1", 2'b01, 2'b00, 1'b1, 1'b1);
        tick();
        chk_out("rr_gap2", 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("rr_g3", 2'b10, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("rr_g3_done", 2'b00, 2'b00, 1'b0, 1'b0);
        dreq    = 2'b00;
        ram_ack = 1'b0;

        // Fetch starvation: dptr=0, state idle.
        dreq    = 2'b11;
        ireq    = 2'b01;
        ram_ack = 1'b1;
        tick();
        chk_out("st_d1", 2'b01, 2'b00, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("st_gap1", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("st_cnt3", 32'(dut.starve_cnt), 32'd3);
        tick();
        chk_out("st_d2", 2'b10, 2'b00, 1'b0, 1'b1);
        chk("st_cnt4", 32'(dut.starve_cnt), 32'd4);
        tick();
        tick();
        chk_out("st_gap2", 2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        chk_out("st_fetch", 2'b00, 2'b01, 1'b0, 1'b1);
        tick();
        chk_out("st_fetch_done", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("st_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        dreq    = 2'b00;
        ireq    = 2'b00;
        ram_ack = 1'b0;
        tick();

        // Data wins over a non-starved fetch.
        dreq = 2'b10;
        ireq = 2'b01;
        tick();
        chk_out("pri_data", 2'b10, 2'b00, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        tick();
        chk_out("pri_gap", 2'b00, 2'b00, 1'b0, 1'b0);
        dreq    = 2'b00;
        ram_ack = 1'b0;
        tick();
        chk_out("pri_fetch", 2'b00, 2'b01, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("pri_fetch_done", 2'b00, 2'b00, 1'b0, 1'b0);
        ireq    = 2'b00;
        ram_ack = 1'b0;

        // Abort: dptr=0 after the 10 burst.
        dreq = 2'b01;
        tick();
        chk_out("ab_grant", 2'b01, 2'b00, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("ab_beat1", 2'b01, 2'b00, 1'b1, 1'b1);
        dreq = 2'b00;
        tick();
        chk_out("ab_drop", 2'b00, 2'b00, 1'b0, 1'b0);
        ram_ack = 1'b0;
        dreq    = 2'b11;
        tick();
        chk_out("ab_ptr_adv", 2'b10, 2'b00, 1'b0, 1'b1);
        dreq = 2'b00;
        tick();
        chk_out("ab_drop2", 2'b00, 2'b00, 1'b0, 1'b0);

        // Async reset mid-burst.
        dreq = 2'b01;
        tick();
        chk_out("rst_grant", 2'b01, 2'b00, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("rst_beat1", 2'b01, 2'b00, 1'b1, 1'b1);
        ram_ack = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk_out("rst_async", 2'b00, 2'b00, 1'b0, 1'b0);
        dreq = 2'b00;
        tick();
        nRST = 1'b1;
        dreq = 2'b10;
        tick();
        chk_out("rst_fresh", 2'b10, 2'b00, 1'b0, 1'b1);
        ram_ack = 1'b1;
        tick();
        chk_out("rst_fresh_b1", 2'b10, 2'b00, 1'b1, 1'b1);
        tick();
        chk_out("rst_fresh_done", 2'b00, 2'b00, 1'b0, 1'b0);
        dreq    = 2'b00;
        ram_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
